// File: rtl/exp_prng_pkg.sv
// rtl/exp_prng_pkg.sv - shared widths and state type for the exponential PRNG stage and event timer
package exp_prng_pkg;

  localparam int DEF_X_WID     = 16;
  localparam int DEF_SHIFT_WID = 4;
  localparam int DEF_CNT_WID   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRE  = 2'd2
  } timer_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear priority and sticky saturation flag
module sat_counter
  import exp_prng_pkg::*;
#(
  parameter int CNT_WID = DEF_CNT_WID
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [CNT_WID-1:0] count_o,
  output logic               sat_o
);

  logic [CNT_WID-1:0] count_q, count_d;
  logic               sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr_i) begin
      // Clear wins even over an increment arriving in the same cycle.
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (inc_i && (count_q != '1)) begin
        count_d = count_q + CNT_WID'(1);
      end
      sat_d = sat_q | (count_d == '1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/exp_event_timer.sv
// rtl/exp_event_timer.sv - counts down exponential interval samples and pulses event_o at expiry
module exp_event_timer
  import exp_prng_pkg::*;
#(
  parameter int X_WID     = DEF_X_WID,
  parameter int SHIFT_WID = DEF_SHIFT_WID,
  parameter int CNT_WID   = DEF_CNT_WID
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [SHIFT_WID-1:0] shift_i,
  input  logic [X_WID-1:0]     sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  output logic                 event_o,
  output logic                 busy_o,
  output logic [CNT_WID-1:0]   event_count_o,
  output logic                 count_sat_o
);

  timer_state_e     state_q, state_d;
  logic [X_WID-1:0] cnt_q, cnt_d;
  logic             event_q, event_d;
  logic             busy_q, busy_d;
  logic [X_WID-1:0] interval;
  logic             accept;

  // FIRE accepts the next sample so a free-running source gives back-to-back intervals.
  assign sample_ready_o = en_i && !rst_i && ((state_q == ST_IDLE) || (state_q == ST_FIRE));
  assign accept         = sample_valid_i && sample_ready_o;
  assign interval       = sample_i >> shift_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_COUNT;
          cnt_d   = interval;
        end
      end
      ST_COUNT: begin
        if (en_i) begin
          if (cnt_q == '0) begin
            state_d = ST_FIRE;
          end else begin
            cnt_d = cnt_q - X_WID'(1);
          end
        end
      end
      ST_FIRE: begin
        if (accept) begin
          state_d = ST_COUNT;
          cnt_d   = interval;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    event_d = (state_d == ST_FIRE);
    busy_d  = (state_d == ST_COUNT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      event_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
      busy_q  <= busy_d;
    end
  end

  assign event_o = event_q;
  assign busy_o  = busy_q;

  sat_counter #(
    .CNT_WID(CNT_WID)
  ) u_sat_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .inc_i  (event_q),
    .count_o(event_count_o),
    .sat_o  (count_sat_o)
  );

endmodule

// File: tb/tb_exp_event_timer.sv
// tb/tb_exp_event_timer.sv - directed and randomized checks of exp_event_timer against a schedule model
module tb_exp_event_timer;

  localparam int XW = 16;
  localparam int SW = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [SW-1:0] shift = '0;
  logic [XW-1:0] sample = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          ev;
  logic          busy;
  logic [CW-1:0] count;
  logic          sat;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  exp_event_timer #(
    .X_WID    (XW),
    .SHIFT_WID(SW),
    .CNT_WID  (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .clr_i         (clr),
    .shift_i       (shift),
    .sample_i      (sample),
    .sample_valid_i(valid),
    .sample_ready_o(ready),
    .event_o       (ev),
    .busy_o        (busy),
    .event_count_o (count),
    .count_sat_o   (sat)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted sample schedules one event at accept_cycle + interval + 2,
  // pushed back one cycle for every paused cycle while the interval is pending.
  longint cyc = 0;
  longint due = 0;
  bit     pend = 1'b0;
  int     mcount = 0;
  bit     msat = 1'b0;
  bit     e_ev, e_busy, e_rdy;

  always @(negedge clk) begin
    e_ev   = pend && (cyc == due);
    e_busy = pend && (cyc < due);
    e_rdy  = en && !rst && !e_busy;
    chk("m_event", ev, e_ev);
    chk("m_busy", busy, e_busy);
    chk("m_ready", ready, e_rdy);
    chk("m_count", count, mcount);
    chk("m_sat", sat, msat);
    if (rst) begin
      pend = 1'b0;
      mcount = 0;
      msat = 1'b0;
    end else begin
      if (e_busy && !en) due++;
      if (e_ev) pend = 1'b0;
      if (valid && e_rdy) begin
        pend = 1'b1;
        due = cyc + longint'(sample >> shift) + 2;
      end
      if (clr) begin
        mcount = 0;
        msat = 1'b0;
      end else if (e_ev && mcount < CMAX) begin
        mcount++;
      end
      if (mcount == CMAX) msat = 1'b1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; en = 1'b1; valid = 1'b0; clr = 1'b0;
    #1;
    chk("rst_ready", ready, 1'b0);
    tick();
    rst = 1'b0; en = 1'b1; valid = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_event", ev, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_sat", sat, 1'b0);
    chk("rst_ready_after", ready, 1'b1);
  endtask

  initial begin
    tick();
    tick();

    // interval 5: event at t+7, busy t+1..t+6, count 1 at t+8
    do_reset();
    sample = 16'd5; shift = 4'd0; valid = 1'b1;
    #1;
    chk("s1_ready", ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick(); valid = 1'b0; #1;
      chk("s1_event", ev, (k == 7));
      chk("s1_busy", busy, (k >= 1 && k <= 6));
      if (k == 8) chk("s1_count", count, 1);
    end

    // 0x40 >> 4 = 4: event at t+6
    do_reset();
    sample = 16'h0040; shift = 4'd4; valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(); valid = 1'b0; #1;
      chk("s2_event", ev, (k == 6));
    end

    // interval 0 then back-to-back 0xFFFF >> 15 = 1 accepted in FIRE
    do_reset();
    sample = 16'd0; shift = 4'd0; valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin sample = 16'hFFFF; shift = 4'd15; end
      if (k == 3) valid = 1'b0;
      #1;
      chk("s3_event", ev, (k == 2 || k == 5));
    end

    // free-running sample 3: period 5
    do_reset();
    sample = 16'd3; shift = 4'd0; valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) valid = 1'b0;
      #1;
      chk("s4_event", ev, (k % 5 == 0) && (k <= 15));
      if (k == 16) chk("s4_count", count, 3);
    end

    // pause during count
    do_reset();
    sample = 16'd5; shift = 4'd0; valid = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(); valid = 1'b0; en = !(k >= 3 && k <= 5); #1;
      chk("s5_event", ev, (k == 10));
      if (k >= 3 && k <= 5) chk("s5_ready", ready, 1'b0);
    end
    en = 1'b1;

    // saturation after 16 events, then clear coincident with an event
    do_reset();
    sample = 16'd0; shift = 4'd0; valid = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick(); clr = (k == 34); valid = (k < 34); #1;
      chk("s6_event", ev, (k % 2 == 0) && (k <= 34));
      if (k == 33) begin
        chk("s6_count_sat", count, 15);
        chk("s6_sat", sat, 1'b1);
      end
      if (k == 35) begin
        chk("s6_count_clr", count, 0);
        chk("s6_sat_clr", sat, 1'b0);
      end
    end
    clr = 1'b0;

    // reset while cnt == 2
    do_reset();
    sample = 16'd0; valid = 1'b1;
    tick(); valid = 1'b0;
    tick();
    tick(); #1;
    chk("s7_count_pre", count, 1);
    sample = 16'd5; valid = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick(); valid = 1'b0; rst = (j == 4); #1;
      if (j == 4) chk("s7_busy_pre", busy, 1'b1);
      if (j >= 5) chk("s7_event", ev, 1'b0);
      if (j == 5) begin
        chk("s7_busy", busy, 1'b0);
        chk("s7_count", count, 0);
        chk("s7_ready", ready, 1'b1);
      end
    end

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst   = ($urandom % 200) == 0;
      en    = ($urandom % 8) != 0;
      clr   = ($urandom % 64) == 0;
      valid = ($urandom % 3) != 0;
      if (($urandom % 4) == 0) begin
        sample = XW'($urandom);
        shift  = SW'(10 + $urandom_range(0, 5));
      end else begin
        sample = XW'($urandom % 12);
        shift  = SW'($urandom % 3);
      end
    end

    tick();
    rst = 1'b1;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
